uart_tx_port: RTL and testbench

Memory-mapped UART transmitter peripheral for the MIPS microcontroller bus. It is the responder that sits on one decoder slot (ce_out[n], rw_out[n], irq_source[n]) next to the GPIO port and timer. It accepts bytes written by the CPU into a small FIFO and serialises them 8N1 on a single output pin. It can raise a level interrupt when transmission has drained.

---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_tx_port_fifo.sv | 62 ++++++
 rtl/uart_tx_port.sv | 167 ++++++++++++++++
 tb/tb_uart_tx_port.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the memory-mapped UART transmitter.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic [1:0] ADDR_DATA   = 2'b00;
    localparam logic [1:0] ADDR_DIV    = 2'b01;
    localparam logic [1:0] ADDR_STATUS = 2'b10;
    localparam logic [1:0] ADDR_IRQEN  = 2'b11;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_BUSY    = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_CNT_LSB = 4;

endpackage

// File: rtl/uart_tx_port_fifo.sv
// Synchronous FIFO with combinational head output; push is accepted when full
// only if a pop happens on the same edge.
module tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_din,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign w_do_pop  = i_pop && (r_count != '0);
    assign w_do_push = i_push && ((r_count != FULL_CNT) || w_do_pop);

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_dout  = r_mem[r_rd_ptr];
    assign o_full  = (r_count == FULL_CNT);
    assign o_empty = (r_count == '0);
    assign o_count = r_count;

endmodule

// File: rtl/uart_tx_port.sv
// Bus-mapped 8N1 UART transmitter: CPU writes bytes into a FIFO, the FSM pops
// one per frame (pop one edge after a push into an idle block); full FIFO drops writes.
module uart_tx_port
    import uart_tx_pkg::*;
#(
    parameter int         DATA_WIDTH     = 32,
    parameter int         FIFO_DEPTH     = 8,
    parameter int         DEFAULT_DIV    = 217,
    parameter logic [1:0] TX_DATA_ADDR   = ADDR_DATA,
    parameter logic [1:0] TX_DIV_ADDR    = ADDR_DIV,
    parameter logic [1:0] TX_STATUS_ADDR = ADDR_STATUS,
    parameter logic [1:0] TX_IRQEN_ADDR  = ADDR_IRQEN
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic [1:0]            address,
    input  logic                  rw,
    input  logic                  ce,
    output logic                  irq,
    output logic                  tx
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    tx_state_t   r_state;
    logic [15:0] r_div;
    logic [15:0] r_bit_div;
    logic [15:0] r_timer;
    logic [2:0]  r_bit_idx;
    logic [7:0]  r_shift;
    logic        r_tx;
    logic        r_ovf;
    logic        r_irq_en;

    logic          w_wr;
    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic          w_busy;
    logic [7:0]    w_fifo_dout;
    logic [CW-1:0] w_count;
    logic [7:0]    w_status;
    logic          w_unused_data;

    assign w_wr          = ce && rw;
    assign w_push        = w_wr && (address == TX_DATA_ADDR);
    assign w_pop         = (r_state == ST_IDLE) && !w_empty;
    assign w_busy        = (r_state != ST_IDLE);
    assign w_unused_data = ^data_in[DATA_WIDTH-1:16];

    tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   (data_in[7:0]),
        .o_dout  (w_fifo_dout),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div    <= 16'(DEFAULT_DIV);
            r_irq_en <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (w_wr) begin
            case (address)
                TX_DIV_ADDR:    r_div    <= (data_in[15:0] == 16'd0) ? 16'd1 : data_in[15:0];
                TX_STATUS_ADDR: r_ovf    <= 1'b0;
                TX_IRQEN_ADDR:  r_irq_en <= data_in[0];
                TX_DATA_ADDR: begin
                    // a same-edge pop makes room, so only a truly blocked push is an overflow
                    if (w_full && !w_pop) begin
                        r_ovf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_status                     = '0;
        w_status[STAT_FULL]          = w_full;
        w_status[STAT_EMPTY]         = w_empty;
        w_status[STAT_BUSY]          = w_busy;
        w_status[STAT_OVF]           = r_ovf;
        w_status[STAT_CNT_LSB +: 4]  = 4'(w_count);
        data_out = '0;
        case (address)
            TX_DIV_ADDR:    data_out[15:0] = r_div;
            TX_STATUS_ADDR: data_out[7:0]  = w_status;
            TX_IRQEN_ADDR:  data_out[0]    = r_irq_en;
            default:        data_out       = '0;
        endcase
    end

    // Divisor is captured into r_bit_div at pop so mid-frame DIV writes wait for the next frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_tx      <= 1'b1;
            r_timer   <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_bit_div <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    if (!w_empty) begin
                        r_shift   <= w_fifo_dout;
                        r_bit_div <= r_div;
                        r_timer   <= r_div - 16'd1;
                        r_bit_idx <= '0;
                        r_tx      <= 1'b0;
                        r_state   <= ST_START;
                    end
                end
                ST_START: begin
                    if (r_timer == 16'd0) begin
                        r_timer <= r_bit_div - 16'd1;
                        r_tx    <= r_shift[0];
                        r_state <= ST_DATA;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_DATA: begin
                    if (r_timer == 16'd0) begin
                        r_timer <= r_bit_div - 16'd1;
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= ST_STOP;
                        end else begin
                            r_shift   <= {1'b0, r_shift[7:1]};
                            r_tx      <= r_shift[1];
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                ST_STOP: begin
                    if (r_timer == 16'd0) begin
                        r_state <= ST_IDLE;
                    end else begin
                        r_timer <= r_timer - 16'd1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign tx  = r_tx;
    assign irq = r_irq_en && w_empty && !w_busy;

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: directed bus traffic plus a line receiver that checks
// each decoded frame against a queue of expected bytes.
module tb_uart_tx_port;

    logic        clk;
    logic        rst;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic [1:0]  address;
    logic        rw;
    logic        ce;
    logic        irq;
    logic        tx;

    localparam logic [1:0] A_DATA   = 2'b00;
    localparam logic [1:0] A_DIV    = 2'b01;
    localparam logic [1:0] A_STATUS = 2'b10;
    localparam logic [1:0] A_IRQEN  = 2'b11;

    typedef struct {
        logic [7:0] b;
        int         d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic mon_on   = 1'b1;

    uart_tx_port dut (
        .clk      (clk),
        .rst      (rst),
        .data_in  (data_in),
        .data_out (data_out),
        .address  (address),
        .rw       (rw),
        .ce       (ce),
        .irq      (irq),
        .tx       (tx)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic note_fail(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        @(negedge clk);
        ce = 1'b1; rw = 1'b1; address = a; data_in = d;
        @(negedge clk);
        ce = 1'b0; rw = 1'b0;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [31:0] q);
        @(negedge clk);
        ce = 1'b1; rw = 1'b0; address = a;
        #1;
        q = data_out;
        ce = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int d);
        exp_t e;
        e.b = b;
        e.d = d;
        exp_q.push_back(e);
        bus_write(A_DATA, {24'd0, b});
    endtask

    // Polls STATUS once per cycle; index i counts cycles after the pop edge.
    task automatic wait_idle(input string name, input int start_i, input int limit,
                             output int first_idle, output logic saw_irq);
        logic [31:0] s;
        int i;
        i = start_i;
        first_idle = -1;
        saw_irq = 1'b0;
        while (i <= limit) begin
            bus_read(A_STATUS, s);
            if (!s[2] && s[1]) begin
                first_idle = i;
                break;
            end
            saw_irq = saw_irq | irq;
            i++;
        end
        if (first_idle < 0) note_fail({name, "_timeout"});
    endtask

    initial begin : monitor
        logic       prev;
        exp_t       e;
        logic [7:0] got;
        int         m;
        prev = 1'b1;
        got  = '0;
        forever begin
            @(negedge clk);
            if (mon_on && prev && (tx == 1'b0)) begin
                if (exp_q.size() == 0) begin
                    note_fail("unexpected_frame");
                end else begin
                    e = exp_q.pop_front();
                    m = 0;
                    while (m < e.d / 2) begin @(negedge clk); m++; end
                    check("start_bit", {31'd0, tx}, 32'd0);
                    for (int k = 0; k < 8; k++) begin
                        while (m < (k + 1) * e.d + e.d / 2) begin @(negedge clk); m++; end
                        got[k] = tx;
                    end
                    while (m < 9 * e.d + e.d / 2) begin @(negedge clk); m++; end
                    check("stop_bit", {31'd0, tx}, 32'd1);
                    while (m < 10 * e.d - 1) begin @(negedge clk); m++; end
                    check("rx_byte", {24'd0, got}, {24'd0, e.b});
                end
            end
            prev = tx;
        end
    end

    initial begin : stim
        logic [31:0] q;
        logic [9:0]  frame;
        int          idle_at;
        logic        irq_seen;
        int          lows;

        rst = 1'b1; ce = 1'b0; rw = 1'b0; address = A_DATA; data_in = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd0);
        bus_read(A_STATUS, q); check("reset_status", q, 32'h2);
        bus_read(A_DIV, q);    check("reset_div", q, 32'd217);
        bus_read(A_IRQEN, q);  check("reset_irqen", q, 32'd0);
        bus_read(A_DATA, q);   check("data_read_zero", q, 32'd0);

        // 0x55 at DIV=4: cycle-exact line and busy profile
        bus_write(A_DIV, 32'd4);
        bus_read(A_DIV, q); check("div4_read", q, 32'd4);
        send_byte(8'h55, 4);
        frame = {1'b1, 8'h55, 1'b0};
        for (int i = 0; i < 40; i++) begin
            bus_read(A_STATUS, q);
            check($sformatf("tx55_c%0d", i), {31'd0, tx}, {31'd0, frame[i / 4]});
            check($sformatf("busy55_c%0d", i), {31'd0, q[2]}, 32'd1);
        end
        bus_read(A_STATUS, q);
        check("busy55_drop", {31'd0, q[2]}, 32'd0);
        check("tx55_idle", {31'd0, tx}, 32'd1);

        // Nine bytes while the first frame is in flight, then an overflow write
        bus_write(A_DIV, 32'd20);
        for (int i = 0; i < 9; i++) send_byte(8'hA0 + 8'(i), 20);
        bus_write(A_DATA, 32'hEE);
        bus_read(A_STATUS, q); check("status_full_ovf", q, 32'h8D);
        bus_write(A_STATUS, 32'd0);
        bus_read(A_STATUS, q); check("status_ovf_clr", q, 32'h85);
        wait_idle("drain9", 0, 5000, idle_at, irq_seen);
        check("drain9_queue", exp_q.size(), 32'd0);

        // Interrupt on drained, idle block
        bus_write(A_DIV, 32'd2);
        bus_write(A_IRQEN, 32'd1);
        bus_read(A_IRQEN, q); check("irqen_read", q, 32'd1);
        check("irq_idle_high", {31'd0, irq}, 32'd1);
        send_byte(8'hA3, 2);
        check("irq_after_push", {31'd0, irq}, 32'd0);
        wait_idle("irq_frame", 0, 500, idle_at, irq_seen);
        check("irq_frame_len", idle_at, 32'd20);
        check("irq_low_busy", {31'd0, irq_seen}, 32'd0);
        check("irq_back_high", {31'd0, irq}, 32'd1);

        // DIV of 0 reads as 1, frame is 10 clocks
        bus_write(A_DIV, 32'd0);
        bus_read(A_DIV, q); check("div0_read", q, 32'd1);
        send_byte(8'h3C, 1);
        wait_idle("div1_frame", 0, 500, idle_at, irq_seen);
        check("div1_frame_len", idle_at, 32'd10);

        // Mid-frame DIV change applies only to the following frame
        bus_write(A_DIV, 32'd3);
        send_byte(8'hC5, 3);
        bus_write(A_DIV, 32'd6);
        send_byte(8'h81, 6);
        wait_idle("divchg", 4, 1000, idle_at, irq_seen);
        check("divchg_len", idle_at, 32'd91);

        // Reset in the middle of a frame discards the queued bytes
        bus_write(A_IRQEN, 32'd0);
        mon_on = 1'b0;
        bus_write(A_DIV, 32'd4);
        bus_write(A_DATA, 32'h11);
        bus_write(A_DATA, 32'h22);
        bus_write(A_DATA, 32'h33);
        repeat (6) @(negedge clk);
        bus_read(A_STATUS, q); check("pre_rst_status", q, 32'h24);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_tx", {31'd0, tx}, 32'd1);
        rst = 1'b0;
        bus_read(A_STATUS, q); check("rst_mid_status", q, 32'h2);
        bus_read(A_DIV, q);    check("rst_mid_div", q, 32'd217);
        lows = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        check("rst_no_tx", lows, 32'd0);
        check("final_queue", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
